ps2_rx: RTL and testbench

PS/2 keyboard receiver that sits directly upstream of the keyboard controller, which decodes scan codes and drives the 7-segment display. It synchronizes and deglitches the external kb_clk/kb_data lines and deserializes 11-bit PS/2 frames: start, 8 data bits LSB-first, odd parity, stop. Each good frame produces one byte on scan_code_out with a single-cycle valid_code strobe. Bad frames are dropped and flagged.

---
 rtl/ps2_rx_if.sv | 21 ++
 rtl/ps2_rx.sv | 169 ++++++++++++++++
 tb/tb_ps2_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// Signal bundle for the PS/2 receiver.
// Raw keyboard lines go in; the decoded byte and its status strobes come out.
interface ps2_rx_if;
  logic       kb_clk;
  logic       kb_data;
  logic [7:0] scan_code_out;
  logic       valid_code;
  logic       parity_err;
  logic       frame_err;

  // master is the keyboard/consumer side, slave is the receiver itself.
  modport master (
    output kb_clk, kb_data,
    input  scan_code_out, valid_code, parity_err, frame_err
  );

  modport slave (
    input  kb_clk, kb_data,
    output scan_code_out, valid_code, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches kb_clk/kb_data, then deserializes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) into one-cycle strobed bytes.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic     clk,
  input  logic     rst,
  ps2_rx_if.slave  ps2
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          sync_clk, sync_data;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          prev_filt_q;
  logic          fall;
  logic          timeout;

  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  // Synchronizers, clock filter and edge history all rest at the idle-high bus level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      prev_filt_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2.kb_clk};
      data_sync_q <= {data_sync_q[0], ps2.kb_data};
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      prev_filt_q <= filt_clk_q;
    end
  end

  assign sync_clk  = clk_sync_q[1];
  assign sync_data = data_sync_q[1];

  // filt_clk only follows sync_clk after FILTER_LEN consecutive disagreeing samples.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (sync_clk != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = sync_clk;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  assign fall = prev_filt_q & ~filt_clk_q;

  // Frame state, counters and the held output byte.
  // NOTE: every register here, the shift register included, is reset so a
  // mid-frame reset leaves no stale partial frame behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      idle_cnt_q <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      idle_cnt_q <= idle_cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // A fall in the same cycle as the timeout wins, so the timeout is masked by it.
  assign timeout = (state_q != S_IDLE) && (idle_cnt_q == TO_LAST) && !fall;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (fall || state_q == S_IDLE) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TO_MAX) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!sync_data) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shreg_d   = {sync_data, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = sync_data;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!sync_data) begin
            ferr_d = 1'b1;
          end else if (^{shreg_q, par_q}) begin
            code_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
    end
  end

  assign ps2.scan_code_out = code_q;
  assign ps2.valid_code    = valid_q;
  assign ps2.parity_err    = perr_q;
  assign ps2.frame_err     = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: a frame-level model predicts each strobe, its
// cycle and the held byte; a compare process checks the DUT against it every cycle.
module tb_ps2_rx;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 20;
  localparam int LAT            = FILTER_LEN + 3;

  typedef enum int {EV_VALID = 0, EV_PERR = 1, EV_FERR = 2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] code;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ps2_rx_if bus ();

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  ev_t        exp_q[$];
  logic [7:0] model_code = 8'h00;
  logic [7:0] vlog[$];
  int         n_valid = 0, n_perr = 0, n_ferr = 0;
  int         last_valid_cyc = 0, last_ferr_cyc = 0, last_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first nbits of a frame; bit period 2*HALF, data changes while kb_clk is high.
  // A complete frame queues the event the receiver must produce LAT cycles after the stop fall.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input logic stop_bit,
                            input int nbits, input int glitch_at);
    logic [10:0] bits;
    logic        p;
    ev_t         e;
    p    = ~(^data) ^ bad_par;
    bits = {stop_bit, p, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.kb_data = bits[i];
      if (i == glitch_at) begin
        bus.kb_clk = 1'b0;
        tick(3);
        bus.kb_clk = 1'b1;
      end
      tick(HALF);
      bus.kb_clk    = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) begin
        e.cyc  = cyc + LAT;
        e.code = data;
        if (!stop_bit)   e.kind = EV_FERR;
        else if (bad_par) e.kind = EV_PERR;
        else             e.kind = EV_VALID;
        exp_q.push_back(e);
      end
      tick(HALF);
      bus.kb_clk = 1'b1;
    end
  endtask

  // Compare process: outputs are sampled on the falling clk edge.
  always @(negedge clk) begin
    int       nstb;
    ev_kind_e k;
    ev_t      e;
    if (!rst) begin
      exp_q.delete();
      model_code = 8'h00;
      check("reset_outputs", {bus.scan_code_out, bus.valid_code, bus.parity_err, bus.frame_err}, '0);
    end else begin
      nstb = int'(bus.valid_code) + int'(bus.parity_err) + int'(bus.frame_err);
      if (nstb > 1) begin
        check("single_strobe", nstb, 1);
      end else if (nstb == 1) begin
        k = bus.valid_code ? EV_VALID : (bus.parity_err ? EV_PERR : EV_FERR);
        if (k == EV_VALID) begin
          n_valid++;
          vlog.push_back(bus.scan_code_out);
          last_valid_cyc = cyc;
        end else if (k == EV_PERR) begin
          n_perr++;
        end else begin
          n_ferr++;
          last_ferr_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {bus.valid_code, bus.parity_err, bus.frame_err}, 3'b000);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", int'(k), int'(e.kind));
          check("strobe_cycle", cyc, e.cyc);
          if (e.kind == EV_VALID) model_code = e.code;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        check("missing_strobe_cycle", cyc, e.cyc);
      end
      check("scan_code_hold", bus.scan_code_out, model_code);
    end
  end

  initial begin
    int t;
    bus.kb_clk  = 1'b1;
    bus.kb_data = 1'b1;
    rst         = 1'b0;
    tick(4);
    check("reset_scan_code", bus.scan_code_out, 8'h00);
    check("reset_strobes", {bus.valid_code, bus.parity_err, bus.frame_err}, 3'b000);
    rst = 1'b1;
    tick(20);

    // 0x1C with wrong parity: dropped, byte stays at its reset value.
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    tick(60);
    check("perr_scan_kept", bus.scan_code_out, 8'h00);
    check("perr_count", n_perr, 1);
    check("perr_no_valid", n_valid, 0);

    // Good 0x1C, valid_code FILTER_LEN+3 = 11 cycles after the raw stop-bit fall.
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    t = last_fall_cyc;
    tick(60);
    check("good_latency", last_valid_cyc - t, 11);
    check("good_scan_1c", bus.scan_code_out, 8'h1C);

    // Back-to-back 0x1C, 0xF0, 0x1C with no idle gap.
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    tick(60);
    check("seq_count", vlog.size(), 4);
    check("seq_0", vlog[1], 8'h1C);
    check("seq_1", vlog[2], 8'hF0);
    check("seq_2", vlog[3], 8'h1C);

    // Stop bit 0 is a frame error; the following good 0x32 decodes.
    send_frame(8'h32, 1'b0, 1'b0, 11, -1);
    tick(60);
    check("stop_err_count", n_ferr, 1);
    check("stop_err_scan_kept", bus.scan_code_out, 8'h1C);
    send_frame(8'h32, 1'b0, 1'b1, 11, -1);
    tick(60);
    check("after_stop_err_scan", bus.scan_code_out, 8'h32);

    // Start + 4 data bits then silence: frame_err TIMEOUT_CYCLES after the internal
    // fall, i.e. LAT + TIMEOUT_CYCLES = 311 cycles after the last raw fall.
    send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
    t = last_fall_cyc;
    begin
      ev_t e;
      e.kind = EV_FERR;
      e.code = 8'h00;
      e.cyc  = t + LAT + TIMEOUT_CYCLES;
      exp_q.push_back(e);
    end
    tick(TIMEOUT_CYCLES + 60);
    check("timeout_latency", last_ferr_cyc - t, 311);
    check("timeout_count", n_ferr, 2);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    tick(60);
    check("after_timeout_scan", bus.scan_code_out, 8'h1C);

    // 3-cycle low glitch on kb_clk inside a frame is filtered out.
    send_frame(8'hF0, 1'b0, 1'b1, 11, 4);
    tick(60);
    check("glitch_scan", bus.scan_code_out, 8'hF0);

    // A fall with data high in IDLE is ignored.
    bus.kb_data = 1'b1;
    tick(HALF);
    bus.kb_clk = 1'b0;
    tick(HALF);
    bus.kb_clk = 1'b1;
    tick(100);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    tick(60);
    check("idle_fall_scan", bus.scan_code_out, 8'h1C);

    // Reset mid-frame discards the partial frame silently.
    send_frame(8'hA5, 1'b0, 1'b1, 4, -1);
    tick(5);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(50);
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    tick(60);
    check("after_reset_scan", bus.scan_code_out, 8'h1C);
    check("total_valid", n_valid, 9);
    check("total_perr", n_perr, 1);
    check("total_ferr", n_ferr, 2);

    tick(100);
    check("events_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
